cella_access_ctrl: RTL and testbench
====================================

# cella_access_ctrl

Sequencer that sits directly upstream of the array row decoder. It accepts one host command at a time over a valid/ready handshake: write, CAM search, or MAC read. It drives the decoder control bundle (`cs`, `MAC_en`, `read_bar`, `w_en`, `addr`, `data`) for the required number of cycles and uses the self-timed dummy-row completion to end search and MAC accesses. It returns the sensed array result on a valid/ready response channel and precharges (deasserts `cs`) between operations.

## Interface
- `WR_CYCLES`, default 2: cycles `w_en`/`cs` are held in ACT for a write, ≥1.
- `PRE_CYCLES`, default 1: cycles `cs`=0 after each operation, ≥1.
- `TIMEOUT`, default 15: max ACT cycles waiting for `dummy_done`, ≥1.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 2: 00 write, 01 CAM search, 10 MAC, 11 illegal.
- `cmd_addr` in 2: row address.
- `cmd_data` in 4: write data or search key.
- `cmd_rbar` in 1: MAC polarity, copied to `read_bar`.
- `dummy_done` in 1: dummy-row sense complete, level, sampled.
- `array_out` in 4: match lines / MAC sense result, valid when `dummy_done`=1.
- `cs` out 1: array select, to decoder.
- `w_en` out 1: write enable, to decoder.
- `MAC_en` out 1: MAC mode, to decoder.
- `read_bar` out 1: MAC polarity, to decoder.
- `addr` out 2: row address, to decoder.
- `data` out 4: data/key, to decoder.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: host accepts response.
- `rsp_data` out 4: captured `array_out`, 0 for writes.
- `rsp_err` out 1: timeout or illegal op.

## Operation
- All outputs are registered. Reset values: `cs`=`w_en`=`MAC_en`=`read_bar`=0, `addr`=0, `data`=0, `cmd_ready`=0 (becomes 1 in IDLE after reset), `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0. State after reset is PRE with counter=PRE_CYCLES, so the array is precharged first.
- States: PRE, IDLE, SETUP, ACT, RESP.
- PRE: `cs`=0, others held. After PRE_CYCLES cycles, go to IDLE.
- IDLE: `cmd_ready`=1, `cs`=0. On `cmd_valid`&`cmd_ready`, latch the fields.
  - Legal op: go to SETUP. Set `addr`/`data`; set `w_en`=(op==00), `MAC_en`=(op==10), `read_bar`=`cmd_rbar` when op==10, else 0.
  - op 11: go directly to RESP with `rsp_err`=1, `rsp_data`=0. The array is never selected.
- SETUP, 1 cycle: `cs`=1 with stable controls. The decoder captures wordlines on the next edge. Go to ACT.
- ACT, write: hold for WR_CYCLES cycles. Then go to RESP with `rsp_data`=0, `rsp_err`=0. `dummy_done` is ignored.
- ACT, search/MAC: each cycle sample `dummy_done`.
  - If `dummy_done`=1: capture `array_out` into `rsp_data`, `rsp_err`=0, go to RESP.
  - If TIMEOUT cycles elapse without it: `rsp_data`=0, `rsp_err`=1, go to RESP.
  - `dummy_done` on the last allowed cycle counts as success.
- RESP: `cs`=0 on entry. `rsp_valid`=1; `rsp_data`/`rsp_err` are stable until the handshake. On `rsp_valid`&`rsp_ready`, go to PRE and clear `w_en`/`MAC_en`/`read_bar`.
- `cmd_ready`=0 in every state except IDLE; at most one command is in flight.
- Counters are 4 bits wide minimum, sized to max(WR_CYCLES, PRE_CYCLES, TIMEOUT). They count down to 0 and never wrap.
- `rst` in any state, including mid-ACT: next edge forces reset values and PRE. The in-flight command and any pending response are dropped with no response.

## Timing
- Command handshake at edge T. SETUP during T..T+1 with `cs`=1 from T+1. ACT begins at T+2.
- Write: RESP (`rsp_valid`=1) visible after edge T+2+WR_CYCLES.
- Search/MAC with `dummy_done` first seen high in ACT cycle k (k=1 for the first ACT cycle): `rsp_valid` rises after edge T+2+k.
- Illegal op: `rsp_valid`=1 after edge T+1.
- `rsp_ready` held high: the response lasts 1 cycle, then PRE_CYCLES cycles, then `cmd_ready`=1.
- Minimum write turnaround (command to next `cmd_ready`) = 3+WR_CYCLES+PRE_CYCLES cycles.
- `cs` is never high in PRE, IDLE, or RESP, so wordlines are cleared before each new setup.

## Test plan
- Reset then write: `rst` for 2 cycles → all outputs 0. Send op=00, addr=2, data=4'hA. Required: `cs`=1 and `w_en`=1 for 1+WR_CYCLES cycles with addr=2, data=A. Then `rsp_valid` with `rsp_data`=0, `rsp_err`=0.
- CAM search: op=01, data=4'h5. Bench raises `dummy_done` on ACT cycle 3 with `array_out`=4'b0100. Required: `w_en`=0, `MAC_en`=0; `rsp_data`=4'b0100, `rsp_err`=0; `rsp_valid` after edge T+5.
- MAC both polarities: op=10, addr=1, `cmd_rbar`=1, then `cmd_rbar`=0. Required: `MAC_en`=1 and `read_bar` matches each command; each response carries the `array_out` value present at `dummy_done`.
- Timeout and boundary: with TIMEOUT=15, first never assert `dummy_done` → `rsp_err`=1, `rsp_data`=0 after exactly 15 ACT cycles. Then assert `dummy_done` on ACT cycle 15 → success, `rsp_err`=0.
- Backpressure and illegal op: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and data stable, `cs`=0, `cmd_ready`=0 throughout. Send op=11 → `rsp_err`=1 and `cs` never asserted.
- Reset mid-ACT: assert `rst` during a search's ACT. Required: next edge gives `cs`=0 and `rsp_valid`=0, no response for the dropped command. A fresh write completes normally.

Source files
------------

// File: rtl/cella_access_ctrl.sv
// cella_access_ctrl
//
// Sequencer in front of the array row decoder. Accepts one host command at a
// time (write, CAM search, MAC read), drives the decoder control bundle for
// the required number of cycles, ends search/MAC accesses on the self-timed
// dummy-row completion (or a timeout), returns the sensed result on a
// valid/ready response channel, and precharges (cs=0) between operations.
//
// Parameters
//   WR_CYCLES  : cycles w_en/cs are held in ACT for a write (>=1)
//   PRE_CYCLES : cycles cs=0 after each operation (>=1)
//   TIMEOUT    : max ACT cycles waiting for dummy_done (>=1)
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_op                   : 00 write, 01 CAM search, 10 MAC, 11 illegal
//   cmd_addr, cmd_data       : row address, write data / search key
//   cmd_rbar                 : MAC polarity
//   dummy_done, array_out    : dummy-row completion level, array sense result
//   cs, w_en, MAC_en,
//   read_bar, addr, data     : decoder control bundle (all registered)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_data, rsp_err        : captured result, timeout/illegal-op flag

module cella_access_ctrl #(
  parameter int unsigned WR_CYCLES  = 2,
  parameter int unsigned PRE_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_addr,
  input  logic [3:0] cmd_data,
  input  logic       cmd_rbar,
  input  logic       dummy_done,
  input  logic [3:0] array_out,
  output logic       cs,
  output logic       w_en,
  output logic       MAC_en,
  output logic       read_bar,
  output logic [1:0] addr,
  output logic [3:0] data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_err
);

  // Counter wide enough for the largest load value, never narrower than 4 bits.
  localparam int unsigned MaxWp   = (WR_CYCLES > PRE_CYCLES) ? WR_CYCLES : PRE_CYCLES;
  localparam int unsigned MaxAll  = (MaxWp > TIMEOUT) ? MaxWp : TIMEOUT;
  localparam int unsigned CntWRaw = $clog2(MaxAll + 1);
  localparam int unsigned CntW    = (CntWRaw < 4) ? 4 : CntWRaw;

  localparam logic [CntW-1:0] WrLoad  = CntW'(WR_CYCLES);
  localparam logic [CntW-1:0] PreLoad = CntW'(PRE_CYCLES);
  localparam logic [CntW-1:0] ToLoad  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpMac   = 2'b10;
  localparam logic [1:0] OpIll   = 2'b11;

  typedef enum logic [2:0] {
    StPre,
    StIdle,
    StSetup,
    StAct,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       cs_q, cs_d;
  logic       w_en_q, w_en_d;
  logic       mac_en_q, mac_en_d;
  logic       read_bar_q, read_bar_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;

  logic cmd_fire;
  logic rsp_fire;
  logic cnt_last;

  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;
  assign cnt_last = (cnt_q <= CntOne);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPre;
      cnt_q       <= PreLoad;
      cmd_ready_q <= 1'b0;
      cs_q        <= 1'b0;
      w_en_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      read_bar_q  <= 1'b0;
      addr_q      <= 2'b00;
      data_q      <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      cs_q        <= cs_d;
      w_en_q      <= w_en_d;
      mac_en_q    <= mac_en_d;
      read_bar_q  <= read_bar_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StPre: begin
        if (cnt_last) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_op == OpIll) begin
            state_d = StResp;
          end else begin
            // Two cycles in SETUP: one to register the controls, one with cs=1
            // so the decoder captures the wordlines before ACT starts.
            state_d = StSetup;
            cnt_d   = CntOne;
          end
        end
      end
      StSetup: begin
        if (cnt_q != CntZero) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          state_d = StAct;
          cnt_d   = w_en_q ? WrLoad : ToLoad;
        end
      end
      StAct: begin
        if (!w_en_q && dummy_done) begin
          state_d = StResp;
        end else if (cnt_last) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StResp: begin
        if (rsp_fire) begin
          state_d = StPre;
          cnt_d   = PreLoad;
        end
      end
      default: begin
        state_d = StPre;
        cnt_d   = PreLoad;
      end
    endcase
  end

  // Registered-output next values.
  always_comb begin
    cmd_ready_d = cmd_ready_q;
    cs_d        = cs_q;
    w_en_d      = w_en_q;
    mac_en_d    = mac_en_q;
    read_bar_d  = read_bar_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StPre: begin
        cs_d = 1'b0;
        if (cnt_last) begin
          cmd_ready_d = 1'b1;
        end
      end
      StIdle: begin
        cs_d = 1'b0;
        if (cmd_fire) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          data_d      = cmd_data;
          if (cmd_op == OpIll) begin
            // rsp_valid rises one cycle later, from RESP.
            w_en_d     = 1'b0;
            mac_en_d   = 1'b0;
            read_bar_d = 1'b0;
            rsp_data_d = 4'h0;
            rsp_err_d  = 1'b1;
          end else begin
            w_en_d     = (cmd_op == OpWrite);
            mac_en_d   = (cmd_op == OpMac);
            read_bar_d = (cmd_op == OpMac) & cmd_rbar;
          end
        end
      end
      StSetup: begin
        cs_d = 1'b1;
      end
      StAct: begin
        if (w_en_q) begin
          if (cnt_last) begin
            cs_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 4'h0;
            rsp_err_d   = 1'b0;
          end
        end else if (dummy_done) begin
          cs_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = array_out;
          rsp_err_d   = 1'b0;
        end else if (cnt_last) begin
          cs_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 4'h0;
          rsp_err_d   = 1'b1;
        end
      end
      StResp: begin
        cs_d = 1'b0;
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          w_en_d      = 1'b0;
          mac_en_d    = 1'b0;
          read_bar_d  = 1'b0;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
        cs_d        = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign cs        = cs_q;
  assign w_en      = w_en_q;
  assign MAC_en    = mac_en_q;
  assign read_bar  = read_bar_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cella_access_ctrl.sv
// Directed testbench for cella_access_ctrl with default parameters
// (WR_CYCLES=2, PRE_CYCLES=1, TIMEOUT=15). Outputs are sampled 1ns after
// each rising edge; inputs are driven at the same point.

module tb_cella_access_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [3:0] cmd_data;
  logic       cmd_rbar;
  logic       dummy_done;
  logic [3:0] array_out;
  logic       cs;
  logic       w_en;
  logic       MAC_en;
  logic       read_bar;
  logic [1:0] addr;
  logic [3:0] data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;

  int n_tests;
  int n_fail;

  cella_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_rbar  (cmd_rbar),
    .dummy_done(dummy_done),
    .array_out (array_out),
    .cs        (cs),
    .w_en      (w_en),
    .MAC_en    (MAC_en),
    .read_bar  (read_bar),
    .addr      (addr),
    .data      (data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then run until rsp_valid. dummy_done/array_out go high
  // before the edge that ends ACT cycle k (k=0: never). Returns cycles from
  // the command edge to rsp_valid and the number of cycles cs was high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] a,
                        input logic [3:0] d, input logic rb, input int k,
                        input logic [3:0] arr, input logic [2:0] exp_ctl,
                        output int lat, output int cs_cnt);
    int w;
    w = 0;
    while (!cmd_ready && w < 30) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_rbar  = rb;
    array_out = ~arr;
    tick();
    cmd_valid = 1'b0;
    cmd_rbar  = 1'b0;
    check({tag, "_ctl"}, 32'({w_en, MAC_en, read_bar}), 32'(exp_ctl));
    check({tag, "_cs_setup"}, 32'(cs), 32'd0);
    if (op != 2'b11) begin
      check({tag, "_addr_data"}, 32'({addr, data}), 32'({a, d}));
    end
    lat    = 0;
    cs_cnt = 0;
    while (!rsp_valid && lat < 60) begin
      if (k != 0 && lat == k + 1) begin
        dummy_done = 1'b1;
        array_out  = arr;
      end
      if (cs) cs_cnt++;
      tick();
      lat++;
    end
    dummy_done = 1'b0;
    array_out  = 4'h0;
    check({tag, "_cs_resp"}, 32'(cs), 32'd0);
  endtask

  task automatic accept(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ctl_clear"}, 32'({w_en, MAC_en, read_bar}), 32'd0);
  endtask

  int lat;
  int csn;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_addr   = 2'b00;
    cmd_data   = 4'h0;
    cmd_rbar   = 1'b0;
    dummy_done = 1'b0;
    array_out  = 4'h0;
    rsp_ready  = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_outputs",
          32'({cmd_ready, cs, w_en, MAC_en, read_bar, addr, data, rsp_valid, rsp_data, rsp_err}),
          32'd0);
    rst = 1'b0;
    tick();
    check("rst_pre_to_idle", 32'(cmd_ready), 32'd1);

    // Write; dummy_done raised mid-ACT must be ignored.
    run_op("wr", 2'b00, 2'd2, 4'hA, 1'b0, 1, 4'h7, 3'b100, lat, csn);
    check("wr_lat", 32'(lat), 32'd4);
    check("wr_cs_cycles", 32'(csn), 32'd3);
    check("wr_rsp", 32'({rsp_valid, rsp_data, rsp_err}), 32'({1'b1, 4'h0, 1'b0}));
    accept("wr");
    check("wr_pre_not_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("wr_turnaround_ready", 32'(cmd_ready), 32'd1);

    // CAM search, dummy_done on ACT cycle 3
    run_op("cam", 2'b01, 2'd0, 4'h5, 1'b0, 3, 4'b0100, 3'b000, lat, csn);
    check("cam_lat", 32'(lat), 32'd5);
    check("cam_cs_cycles", 32'(csn), 32'd4);
    check("cam_rsp", 32'({rsp_data, rsp_err}), 32'({4'b0100, 1'b0}));
    accept("cam");

    // MAC, both polarities
    run_op("mac1", 2'b10, 2'd1, 4'h3, 1'b1, 2, 4'hC, 3'b011, lat, csn);
    check("mac1_lat", 32'(lat), 32'd4);
    check("mac1_rsp", 32'({rsp_data, rsp_err}), 32'({4'hC, 1'b0}));
    accept("mac1");
    run_op("mac0", 2'b10, 2'd1, 4'h3, 1'b0, 1, 4'h6, 3'b010, lat, csn);
    check("mac0_lat", 32'(lat), 32'd3);
    check("mac0_rsp", 32'({rsp_data, rsp_err}), 32'({4'h6, 1'b0}));
    accept("mac0");

    // Timeout, then success on the last allowed cycle
    run_op("to", 2'b01, 2'd3, 4'hF, 1'b0, 0, 4'h9, 3'b000, lat, csn);
    check("to_lat", 32'(lat), 32'd17);
    check("to_rsp", 32'({rsp_data, rsp_err}), 32'({4'h0, 1'b1}));
    accept("to");
    run_op("edge", 2'b01, 2'd3, 4'hF, 1'b0, 15, 4'h9, 3'b000, lat, csn);
    check("edge_lat", 32'(lat), 32'd17);
    check("edge_rsp", 32'({rsp_data, rsp_err}), 32'({4'h9, 1'b0}));
    accept("edge");

    // Backpressure
    run_op("bp", 2'b01, 2'd1, 4'h2, 1'b0, 1, 4'hB, 3'b000, lat, csn);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 32'({rsp_valid, rsp_data, rsp_err, cs, cmd_ready}),
            32'({1'b1, 4'hB, 1'b0, 1'b0, 1'b0}));
      tick();
    end
    accept("bp");

    // Illegal op
    run_op("ill", 2'b11, 2'd2, 4'h1, 1'b0, 0, 4'h5, 3'b000, lat, csn);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_cs_cycles", 32'(csn), 32'd0);
    check("ill_rsp", 32'({rsp_data, rsp_err}), 32'({4'h0, 1'b1}));
    accept("ill");

    // Reset during a search's ACT
    while (!cmd_ready) tick();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_addr  = 2'd2;
    cmd_data  = 4'h4;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    check("mid_cs_active", 32'(cs), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_out", 32'({cs, rsp_valid, cmd_ready}), 32'd0);
    rst = 1'b0;
    csn = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) csn++;
      tick();
    end
    check("mid_no_rsp", 32'(csn), 32'd0);
    run_op("wr2", 2'b00, 2'd1, 4'h3, 1'b0, 0, 4'h0, 3'b100, lat, csn);
    check("wr2_lat", 32'(lat), 32'd4);
    check("wr2_rsp", 32'({rsp_data, rsp_err}), 32'({4'h0, 1'b0}));
    accept("wr2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
